// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit frame controller.
package uart_tx_ctrl_pkg;

  // Frame sequencing states; encodings kept identical to the legacy constants.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Serial line levels.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Parity type selector values.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage : uart_tx_ctrl_pkg

// File: rtl/uart_tx_ctrl_parity.sv
// Registered parity calculator; captures the frame's parity bit when a
// request is accepted so later changes to data or type do not disturb it.
module uart_tx_parity
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  parity_o
);

  logic parity_q;
  logic parity_d;

  // Even parity is the XOR of all data bits; odd parity is its inverse.
  always_comb begin
    parity_d = parity_q;
    if (load_i) begin
      parity_d = (^data_i) ^ (par_typ_i == PAR_ODD);
    end
  end

  // Parity latch with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_o = parity_q;

endmodule : uart_tx_parity

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start, data, optional parity and
// stop bits at one bit per clock, enables the external serializer and muxes
// the selected bit onto the TX line.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_en_q, par_en_d;
  logic             ser_en_q, ser_en_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic             accept;
  logic             timeout;
  logic             parity_bit;

  // A new request is taken only when the line is idle or finishing a stop bit.
  assign accept = Data_Valid && ((state_q == ST_IDLE) || (state_q == ST_STOP));

  uart_tx_parity #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .load_i   (accept),
    .data_i   (P_DATA),
    .par_typ_i(PAR_TYP),
    .parity_o (parity_bit)
  );

  // Next-state, bit counter and timeout decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    par_en_d = par_en_q;
    timeout  = 1'b0;

    if (accept) begin
      par_en_d = PAR_EN;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        cnt_d = cnt_q + 1'b1;
        // A missing ser_done by the last data slot is treated as the end of data.
        if (ser_done || (cnt_d == CNT_W'(DATA_WIDTH))) begin
          timeout = !ser_done;
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        state_d = ST_STOP;
      end
      ST_STOP: begin
        state_d = accept ? ST_START : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered alongside the state so they line up with it.
    ser_en_d    = (state_d == ST_START) || (state_d == ST_DATA);
    busy_d      = (state_d != ST_IDLE);
    frame_err_d = timeout;
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      par_en_q    <= 1'b0;
      ser_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      par_en_q    <= par_en_d;
      ser_en_q    <= ser_en_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  // TX line mux driven from the registered state.
  always_comb begin
    TX_OUT = LINE_IDLE;
    unique case (state_q)
      ST_IDLE:   TX_OUT = LINE_IDLE;
      ST_START:  TX_OUT = START_BIT;
      ST_DATA:   TX_OUT = ser_data;
      ST_PARITY: TX_OUT = parity_bit;
      ST_STOP:   TX_OUT = LINE_IDLE;
      default:   TX_OUT = LINE_IDLE;
    endcase
  end

  assign ser_en    = ser_en_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule : uart_tx_ctrl

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl with a behavioural serializer and a
// per-cycle expectation queue.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       ser_data;
  logic       ser_done;
  logic       ser_en;
  logic       TX_OUT;
  logic       busy;
  logic       frame_err;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(
    .DATA_WIDTH(8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .ser_data  (ser_data),
    .ser_done  (ser_done),
    .ser_en    (ser_en),
    .TX_OUT    (TX_OUT),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // Serializer model: loads P_DATA on the first enabled cycle, then shifts LSB first.
  logic [7:0]  sh_q     = '0;
  int unsigned idx_q    = 0;
  logic        active_q = 1'b0;
  logic        stuck    = 1'b0;

  always @(posedge CLK) begin
    if (!ser_en) begin
      active_q <= 1'b0;
    end else if (!active_q) begin
      sh_q     <= P_DATA;
      idx_q    <= 0;
      active_q <= 1'b1;
    end else begin
      idx_q <= idx_q + 1;
    end
  end

  assign ser_data = active_q ? sh_q[idx_q[2:0]] : 1'b0;
  assign ser_done = active_q && (idx_q == 7) && !stuck;

  typedef struct packed {
    logic tx;
    logic busy;
    logic sen;
    logic ferr;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // One clock: sample on the falling edge and compare against the queue head.
  task automatic step(input string tag);
    exp_t e;
    @(negedge CLK);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed scoreboard empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".tx"},   TX_OUT,    e.tx);
      chk({tag, ".busy"}, busy,      e.busy);
      chk({tag, ".sen"},  ser_en,    e.sen);
      chk({tag, ".ferr"}, frame_err, e.ferr);
    end
  endtask

  task automatic push_idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back('{tx: 1'b1, busy: 1'b0, sen: 1'b0, ferr: 1'b0});
  endtask

  // Expected line/enable pattern of one frame, truncated to maxlen cycles.
  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic ferr, input int unsigned maxlen);
    exp_t f[$];
    f.push_back('{tx: 1'b0, busy: 1'b1, sen: 1'b1, ferr: 1'b0});
    for (int unsigned i = 0; i < 8; i++) f.push_back('{tx: d[i], busy: 1'b1, sen: 1'b1, ferr: 1'b0});
    if (pe) f.push_back('{tx: (^d) ^ pt, busy: 1'b1, sen: 1'b0, ferr: ferr});
    f.push_back('{tx: 1'b1, busy: 1'b1, sen: 1'b0, ferr: pe ? 1'b0 : ferr});
    for (int unsigned i = 0; i < f.size() && i < maxlen; i++) exp_q.push_back(f[i]);
  endtask

  // One-cycle request; frame settings and data are disturbed once latched.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic ferr,
                      input int unsigned n_idle, input string tag);
    int unsigned len;
    len = pe ? 11 : 10;
    push_frame(d, pe, pt, ferr, 99);
    push_idle(n_idle);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    step(tag);
    Data_Valid = 1'b0;
    PAR_EN     = ~pe;
    PAR_TYP    = ~pt;
    step(tag);
    P_DATA = ~d;
    repeat (len - 2 + n_idle) step(tag);
  endtask

  initial begin
    RST        = 1'b0;
    Data_Valid = 1'b1;
    P_DATA     = 8'hFF;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    // Reset held with a pending request: line stays idle.
    push_idle(2);
    step("reset");
    step("reset");
    RST        = 1'b1;
    Data_Valid = 1'b0;
    push_idle(1);
    step("idle");

    // Plain frame, then even and odd parity frames.
    send(8'b1011_1011, 1'b0, 1'b0, 1'b0, 1, "frame_nopar");
    send(8'b1011_1011, 1'b1, 1'b0, 1'b0, 1, "frame_even");
    send(8'b1011_1011, 1'b1, 1'b1, 1'b0, 1, "frame_odd");

    // Back-to-back frames with Data_Valid held high.
    push_frame(8'hA5, 1'b0, 1'b0, 1'b0, 99);
    push_frame(8'hA5, 1'b0, 1'b0, 1'b0, 99);
    push_idle(1);
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    repeat (20) step("b2b");
    Data_Valid = 1'b0;
    step("b2b");

    // Reset during the 4th data cycle abandons the frame.
    push_frame(8'h5A, 1'b0, 1'b0, 1'b0, 5);
    push_idle(2);
    P_DATA     = 8'h5A;
    Data_Valid = 1'b1;
    step("abort");
    Data_Valid = 1'b0;
    repeat (4) step("abort");
    RST = 1'b0;
    step("abort_rst");
    RST = 1'b1;
    step("abort_rst");
    send(8'h3C, 1'b1, 1'b1, 1'b0, 1, "after_rst");

    // Serializer never signals done: timeout pulse, frame still completes.
    stuck = 1'b1;
    send(8'h96, 1'b0, 1'b0, 1'b1, 2, "timeout");
    send(8'hC3, 1'b1, 1'b0, 1'b1, 1, "timeout_par");
    stuck = 1'b0;
    send(8'h01, 1'b0, 1'b0, 1'b0, 1, "recover");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL drain: observed %0d leftover entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_tx_ctrl
